// File: rtl/clk_div_rst_seq.sv
// Multi-channel clock-enable divider and timed reset-release sequencer.
// Provides a req/ack config port for runtime divider programming and a software reset.
module clk_div_rst_seq #(
  parameter int N_CH     = 4,
  parameter int DIV_W    = 8,
  parameter int INIT_DLY = 8,
  parameter int SEQ_DLY  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              testmode_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wrn_i,
  input  logic [3:0]        cfg_add_i,
  input  logic [31:0]       cfg_data_i,
  output logic              cfg_ack_o,
  output logic [31:0]       cfg_r_data_o,
  output logic [N_CH-1:0]   clk_en_o,
  output logic [N_CH-1:0]   rstn_o,
  output logic              seq_done_o
);

  localparam int DLY_MAX = (INIT_DLY > SEQ_DLY) ? INIT_DLY : SEQ_DLY;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DLY_W-1:0] INIT_LOAD = DLY_W'(INIT_DLY - 1);
  localparam logic [DLY_W-1:0] SEQ_LOAD  = DLY_W'(SEQ_DLY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_STEP, S_DONE} seq_state_e;

  // Config handshake: req must be held until ack; one transfer per ack pulse.
  logic commit, wr_stb, soft_rst;
  assign commit   = cfg_req_i & ~cfg_ack_o;
  assign wr_stb   = commit & ~cfg_wrn_i;
  assign soft_rst = wr_stb & (cfg_add_i == 4'hF) & cfg_data_i[0];

  logic unused_cfg;
  assign unused_cfg = ^cfg_data_i;

  logic [1:0]            rst_sync;
  seq_state_e            seq_state;
  logic [DLY_W-1:0]      dly;
  logic [IDX_W-1:0]      idx;
  logic [N_CH-1:0]       rstn_q;
  logic                  seq_done_q;
  logic [DIV_W-1:0]      div_q  [N_CH];
  logic [DIV_W-1:0]      cnt_q  [N_CH];
  logic [DIV_W-1:0]      pm1    [N_CH];
  logic [N_CH-1:0]       en_q;
  logic [N_CH-1:0]       clk_en_q;
  logic [31:0]           rd_word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      pm1[k] = (div_q[k] <= DIV_W'(1)) ? '0 : div_q[k] - DIV_W'(1);
    end
  end

  // clk_en_q holds "the counter value after this edge equals period-1".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_CH; k++) begin
        div_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      en_q     <= '1;
      clk_en_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_stb && (cfg_add_i == 4'(k))) begin
          div_q[k]    <= cfg_data_i[DIV_W-1:0];
          en_q[k]     <= cfg_data_i[31];
          cnt_q[k]    <= '0;
          clk_en_q[k] <= cfg_data_i[31] & (cfg_data_i[DIV_W-1:0] <= DIV_W'(1));
        end else if (!en_q[k]) begin
          cnt_q[k]    <= '0;
          clk_en_q[k] <= 1'b0;
        end else if (cnt_q[k] == pm1[k]) begin
          cnt_q[k]    <= '0;
          clk_en_q[k] <= (pm1[k] == '0);
        end else begin
          cnt_q[k]    <= cnt_q[k] + DIV_W'(1);
          clk_en_q[k] <= ((cnt_q[k] + DIV_W'(1)) == pm1[k]);
        end
      end
    end
  end

  // The FSM leaves IDLE on the same edge the second synchroniser stage releases.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_state  <= S_IDLE;
      dly        <= '0;
      idx        <= '0;
      rstn_q     <= '0;
      seq_done_q <= 1'b0;
    end else if (soft_rst) begin
      seq_state  <= S_INIT;
      dly        <= INIT_LOAD;
      idx        <= '0;
      rstn_q     <= '0;
      seq_done_q <= 1'b0;
    end else begin
      case (seq_state)
        S_IDLE: begin
          if (rst_sync == 2'b10) begin
            seq_state <= S_INIT;
            dly       <= INIT_LOAD;
          end
        end
        S_INIT: begin
          if (dly == '0) begin
            rstn_q[0] <= 1'b1;
            idx       <= IDX_W'(1);
            if (N_CH == 1) begin
              seq_state  <= S_DONE;
              seq_done_q <= 1'b1;
            end else begin
              seq_state <= S_STEP;
              dly       <= SEQ_LOAD;
            end
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        S_STEP: begin
          if (dly == '0) begin
            rstn_q[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              seq_state  <= S_DONE;
              seq_done_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
              dly <= SEQ_LOAD;
            end
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cfg_add_i == 4'(k)) begin
        rd_word[DIV_W-1:0] = div_q[k];
        rd_word[31]        = en_q[k];
      end
    end
    if (cfg_add_i == 4'hF) begin
      rd_word[N_CH-1:0] = rstn_o;
      rd_word[31]       = seq_done_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_ack_o    <= 1'b0;
      cfg_r_data_o <= '0;
    end else begin
      cfg_ack_o    <= commit;
      cfg_r_data_o <= (commit & cfg_wrn_i) ? rd_word : '0;
    end
  end

  assign clk_en_o   = testmode_i ? '1 : clk_en_q;
  assign rstn_o     = testmode_i ? {N_CH{~rst_i}} : rstn_q;
  assign seq_done_o = seq_done_q;

endmodule

// File: tb/tb_clk_div_rst_seq.sv
// Bench for clk_div_rst_seq: directed sequence plus randomized divider programming,
// checked against a release-time / phase arithmetic model of the outputs.
module tb_clk_div_rst_seq;
  localparam int N_CH     = 4;
  localparam int DIV_W    = 8;
  localparam int INIT_DLY = 8;
  localparam int SEQ_DLY  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              testmode_i;
  logic              cfg_req_i;
  logic              cfg_wrn_i;
  logic [3:0]        cfg_add_i;
  logic [31:0]       cfg_data_i;
  logic              cfg_ack_o;
  logic [31:0]       cfg_r_data_o;
  logic [N_CH-1:0]   clk_en_o;
  logic [N_CH-1:0]   rstn_o;
  logic              seq_done_o;

  clk_div_rst_seq #(
    .N_CH(N_CH), .DIV_W(DIV_W), .INIT_DLY(INIT_DLY), .SEQ_DLY(SEQ_DLY)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .testmode_i(testmode_i),
    .cfg_req_i(cfg_req_i), .cfg_wrn_i(cfg_wrn_i), .cfg_add_i(cfg_add_i),
    .cfg_data_i(cfg_data_i), .cfg_ack_o(cfg_ack_o), .cfg_r_data_o(cfg_r_data_o),
    .clk_en_o(clk_en_o), .rstn_o(rstn_o), .seq_done_o(seq_done_o)
  );

  // clock / edge counter
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: release times and per-channel divider phase origin
  bit m_in_rst;
  int m_rel0;
  int m_div   [N_CH];
  bit m_en    [N_CH];
  int m_clear [N_CH];
  bit m_fresh [N_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N_CH-1:0] exp_rstn();
    logic [N_CH-1:0] r;
    r = '0;
    if (testmode_i) return rst_i ? '0 : '1;
    for (int k = 0; k < N_CH; k++) r[k] = !m_in_rst && (cyc >= m_rel0 + SEQ_DLY * k);
    return r;
  endfunction

  function automatic logic exp_done();
    return !m_in_rst && (cyc >= m_rel0 + SEQ_DLY * (N_CH - 1));
  endfunction

  function automatic logic [N_CH-1:0] exp_clken();
    logic [N_CH-1:0] r;
    int p, j;
    r = '0;
    if (testmode_i) return '1;
    if (m_in_rst) return '0;
    for (int k = 0; k < N_CH; k++) begin
      p = (m_div[k] <= 1) ? 1 : m_div[k];
      j = cyc - m_clear[k];
      if (!m_en[k] || (m_fresh[k] && j == 0)) r[k] = 1'b0;
      else r[k] = ((j + 1) % p) == 0;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] addr);
    logic [31:0] r;
    r = '0;
    if (int'(addr) < N_CH) begin
      r[DIV_W-1:0] = DIV_W'(m_div[addr]);
      r[31]        = m_en[addr];
    end else if (addr == 4'hF) begin
      r[N_CH-1:0] = exp_rstn();
      r[31]       = exp_done();
    end
    return r;
  endfunction

  task automatic model_release();
    m_in_rst = 1'b0;
    m_rel0   = cyc + 2 + INIT_DLY;
    for (int k = 0; k < N_CH; k++) begin
      m_div[k] = 0; m_en[k] = 1'b1; m_clear[k] = cyc; m_fresh[k] = 1'b1;
    end
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input int c);
    if (int'(addr) < N_CH) begin
      m_div[addr]   = int'(data[DIV_W-1:0]);
      m_en[addr]    = data[31];
      m_clear[addr] = c;
      m_fresh[addr] = 1'b0;
    end else if (addr == 4'hF && data[0]) begin
      m_rel0 = c + INIT_DLY;
    end
  endtask

  task automatic check_outs();
    chk("clk_en", 32'(clk_en_o), 32'(exp_clken()));
    chk("rstn", 32'(rstn_o), 32'(exp_rstn()));
    chk("seq_done", 32'(seq_done_o), 32'(exp_done()));
  endtask

  task automatic check_model();
    check_outs();
    chk("ack_idle", 32'(cfg_ack_o), 32'd0);
    chk("rdata_idle", cfg_r_data_o, 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_i);
      check_model();
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(negedge clk_i);
      check_model();
    end
  endtask

  // driver: one config transfer, commit edge is the one where ack rises
  task automatic cfg_xfer(input bit wrn, input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] exp_rd;
    @(negedge clk_i);
    check_model();
    exp_rd     = exp_read(addr);
    cfg_req_i  = 1'b1;
    cfg_wrn_i  = wrn;
    cfg_add_i  = addr;
    cfg_data_i = data;
    @(negedge clk_i);
    chk("cfg_ack", 32'(cfg_ack_o), 32'd1);
    if (wrn) chk("cfg_rdata", cfg_r_data_o, exp_rd);
    else model_write(addr, data, cyc);
    cfg_req_i = 1'b0;
    check_outs();
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  a;
    int f;
    rst_i = 1'b0; testmode_i = 1'b0; cfg_req_i = 1'b0; cfg_wrn_i = 1'b0;
    cfg_add_i = '0; cfg_data_i = '0;
    m_in_rst = 1'b1; m_rel0 = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_div[k] = 0; m_en[k] = 1'b1; m_clear[k] = 0; m_fresh[k] = 1'b1;
    end
    #2 rst_i = 1'b1;
    run(3);
    chk("reset_rstn", 32'(rstn_o), 32'd0);
    chk("reset_clken", 32'(clk_en_o), 32'd0);

    // 1: power-on release sequence
    rst_i = 1'b0;
    f = cyc;
    model_release();
    wait_to(f + 9);
    chk("t1_rstn_pre", 32'(rstn_o), 32'h0);
    wait_to(f + 10);
    chk("t1_rstn_ch0", 32'(rstn_o), 32'h1);
    wait_to(f + 26);
    chk("t1_rstn_ch1", 32'(rstn_o), 32'h3);
    wait_to(f + 42);
    chk("t1_rstn_ch2", 32'(rstn_o), 32'h7);
    wait_to(f + 57);
    chk("t1_done_pre", 32'(seq_done_o), 32'd0);
    wait_to(f + 58);
    chk("t1_rstn_all", 32'(rstn_o), 32'hF);
    chk("t1_done", 32'(seq_done_o), 32'd1);

    // 2: divide-by-3 on channel 0
    cfg_xfer(1'b0, 4'd0, 32'h8000_0003);
    run(12);
    cfg_xfer(1'b1, 4'd0, 32'h0);
    chk("t2_read_lit", exp_read(4'd0), 32'h8000_0003);

    // 3: disabled channel, then enable mid-count
    cfg_xfer(1'b0, 4'd1, 32'h0000_0005);
    run(9);
    cfg_xfer(1'b0, 4'd1, 32'h8000_0005);
    run(12);

    // randomized divider programming and reads
    repeat (6) begin
      a = 4'($urandom_range(0, N_CH - 1));
      d = {1'($urandom_range(0, 1)), 23'd0, 8'($urandom_range(0, 9))};
      cfg_xfer(1'b0, a, d);
      run($urandom_range(3, 15));
      cfg_xfer(1'b1, 4'($urandom_range(0, 15)), 32'h0);
    end
    cfg_xfer(1'b0, 4'd0, 32'h8000_0003);

    // 4: soft reset after DONE replays the sequence
    cfg_xfer(1'b1, 4'hF, 32'h0);
    cfg_xfer(1'b0, 4'hF, 32'h0000_0001);
    wait_to(m_rel0 + SEQ_DLY * (N_CH - 1) + 2);

    // 5: hard reset between ch1 and ch2 release
    cfg_xfer(1'b0, 4'hF, 32'h0000_0001);
    wait_to(m_rel0 + SEQ_DLY + 5);
    rst_i = 1'b1;
    m_in_rst = 1'b1;
    #1;
    chk("t5_rstn", 32'(rstn_o), 32'd0);
    chk("t5_clken", 32'(clk_en_o), 32'd0);
    chk("t5_done", 32'(seq_done_o), 32'd0);
    run(2);
    rst_i = 1'b0;
    model_release();
    cfg_xfer(1'b1, 4'd9, 32'h0);
    cfg_xfer(1'b0, 4'd9, $urandom);
    for (int k = 0; k < N_CH; k++) cfg_xfer(1'b1, 4'(k), 32'h0);
    wait_to(m_rel0 + SEQ_DLY * (N_CH - 1) + 2);

    // 6: testmode during INIT after a soft reset
    cfg_xfer(1'b0, 4'd2, 32'h8000_0004);
    cfg_xfer(1'b0, 4'hF, 32'h0000_0001);
    run(3);
    testmode_i = 1'b1;
    #1;
    chk("t6_clken", 32'(clk_en_o), 32'hF);
    chk("t6_rstn", 32'(rstn_o), 32'hF);
    run(4);
    testmode_i = 1'b0;
    wait_to(m_rel0 + SEQ_DLY * (N_CH - 1) + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
